// File: rtl/strobe_tx_if.sv
// ----------------------------------------------------------------------------
// strobe_tx_if
//   Upstream valid/ready word channel feeding the strobe transmitter.
//
//   Signals:
//     in_data  [WIDTH] upstream word
//     in_valid         upstream word is valid
//     in_ready         transmitter can accept a word this cycle
//
//   Modports:
//     master : the upstream word source (drives in_data/in_valid)
//     slave  : the strobe transmitter   (drives in_ready)
// ----------------------------------------------------------------------------
interface strobe_tx_if #(
    parameter int WIDTH = 3
) ();
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/strobe_tx.sv
// ----------------------------------------------------------------------------
// strobe_tx
//   Transmit end of a strobe-and-data capture link. Words arrive on a
//   valid/ready channel, are buffered in a small FIFO, and are sent out one at
//   a time as a single-cycle strobe `y` with the word on `x`. `x` is held
//   between strobes, and GAP idle cycles are forced between strobes so the
//   receiver's level-sensitive capture always sees settled data.
//
//   Parameters:
//     WIDTH  data width of in_data and x
//     DEPTH  FIFO depth in words (power of 2, >= 2)
//     GAP    idle cycles between consecutive strobes (0..15)
//
//   Ports:
//     clk    sole clock, rising edge
//     rst_n  synchronous active-low reset
//     up     strobe_tx_if.slave : in_data / in_valid / in_ready
//     x      registered data to the receiver, holds the last strobed word
//     y      registered strobe, high exactly one cycle per word
//     busy   FIFO non-empty or FSM not idle
//     level  current FIFO occupancy (0..DEPTH)
//     p      (only with STROBE_TX_PARITY_EN) registered XOR of all bits of x
//
//   Optional feature macro: STROBE_TX_PARITY_EN adds the parity output `p`.
// ----------------------------------------------------------------------------
module strobe_tx #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    strobe_tx_if.slave               up,
    output logic [WIDTH-1:0]         x,
    output logic                     y,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
`ifdef STROBE_TX_PARITY_EN
    ,
    output logic                     p
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_COUNT = LW'(DEPTH);
    // Counter preload leaving the FSM in WAIT for exactly GAP cycles.
    localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    count_reg;
    logic [3:0]       gap_cnt_reg;
    logic [WIDTH-1:0] x_reg;
    logic             y_reg;

    logic             full;
    logic             not_empty;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;

    // in_ready looks only at the registered count, so a pop on the same
    // edge never opens space for that edge's push.
    assign full        = (count_reg == FULL_COUNT);
    assign not_empty   = (count_reg != '0);
    assign up.in_ready = rst_n && !full;
    assign push        = up.in_valid && up.in_ready;
    assign head        = mem[rd_ptr_reg];

    // Pop decision. In WAIT the final counted cycle doubles as the idle
    // check, which keeps strobes exactly GAP+1 cycles apart while words
    // are queued.
    always_comb begin
        pop = 1'b0;
        case (state_reg)
            IDLE:    pop = not_empty;
            SEND:    pop = (GAP == 0) && not_empty;
            WAIT:    pop = (gap_cnt_reg == 4'd0) && not_empty;
            default: pop = 1'b0;
        endcase
    end

    // Storage array, no reset needed: contents are only read behind count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= up.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            gap_cnt_reg <= 4'd0;
            x_reg       <= '0;
            y_reg       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
                x_reg      <= head;
            end
            count_reg <= count_reg + LW'(push) - LW'(pop);

            // Every pop is exactly one strobe, so y simply follows pop.
            y_reg <= pop;

            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        state_reg <= SEND;
                    end
                end
                SEND: begin
                    if (GAP > 0) begin
                        gap_cnt_reg <= GAP_LOAD;
                        state_reg   <= WAIT;
                    end else if (!pop) begin
                        state_reg <= IDLE;
                    end
                end
                WAIT: begin
                    if (gap_cnt_reg == 4'd0) begin
                        state_reg <= pop ? SEND : IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - 4'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef STROBE_TX_PARITY_EN
    logic p_reg;

    // Parity travels with x: loaded on the same pop edges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_reg <= 1'b0;
        end else if (pop) begin
            p_reg <= ^head;
        end
    end

    assign p = p_reg;
`endif

    assign x     = x_reg;
    assign y     = y_reg;
    assign busy  = not_empty || (state_reg != IDLE);
    assign level = count_reg;

endmodule

// File: tb/tb_strobe_tx.sv
// ----------------------------------------------------------------------------
// tb_strobe_tx
//   Directed bench for strobe_tx. Three instances share clk/rst_n and differ
//   only in GAP (1, 0, 3). Expected values are hand-traced per cycle.
// ----------------------------------------------------------------------------
module tb_strobe_tx;

    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    strobe_tx_if #(.WIDTH(3)) if1 ();
    strobe_tx_if #(.WIDTH(3)) if0 ();
    strobe_tx_if #(.WIDTH(3)) if3 ();

    logic [2:0] x1, x0, x3;
    logic       y1, y0, y3;
    logic       busy1, busy0, busy3;
    logic [2:0] level1, level0, level3;
`ifdef STROBE_TX_PARITY_EN
    logic       p1, p0, p3;
`endif

    strobe_tx #(.WIDTH(3), .DEPTH(4), .GAP(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .up    (if1),
        .x     (x1),
        .y     (y1),
        .busy  (busy1),
        .level (level1)
`ifdef STROBE_TX_PARITY_EN
        ,
        .p     (p1)
`endif
    );

    strobe_tx #(.WIDTH(3), .DEPTH(4), .GAP(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .up    (if0),
        .x     (x0),
        .y     (y0),
        .busy  (busy0),
        .level (level0)
`ifdef STROBE_TX_PARITY_EN
        ,
        .p     (p0)
`endif
    );

    strobe_tx #(.WIDTH(3), .DEPTH(4), .GAP(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .up    (if3),
        .x     (x3),
        .y     (y3),
        .busy  (busy3),
        .level (level3)
`ifdef STROBE_TX_PARITY_EN
        ,
        .p     (p3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int e1 [10];
        int e0 [10];
        logic [2:0] w3 [8];
        int idx;
        int strobes;
        int exp_x;
        logic rdy;

        vectors     = 0;
        miscompares = 0;
        e1 = '{0, 1, 0, 2, 0, 3, 0, 4, 0, 0};
        e0 = '{0, 1, 2, 3, 4, 0, 0, 0, 0, 0};
        w3 = '{3'd6, 3'd1, 3'd7, 3'd2, 3'd5, 3'd0, 3'd3, 3'd4};

        if1.in_data = 3'd0; if1.in_valid = 1'b0;
        if0.in_data = 3'd0; if0.in_valid = 1'b0;
        if3.in_data = 3'd0; if3.in_valid = 1'b0;

        // ---- Reset held 2 cycles with in_valid high ----
        rst_n = 1'b0;
        if1.in_valid = 1'b1;
        if1.in_data  = 3'd7;
        tick();
        tick();
        check("rst_x",     32'(x1),           32'd0);
        check("rst_y",     32'(y1),           32'd0);
        check("rst_level", 32'(level1),       32'd0);
        check("rst_busy",  32'(busy1),        32'd0);
        check("rst_ready", 32'(if1.in_ready), 32'd0);
        check("rst_level3",32'(level3),       32'd0);
        rst_n = 1'b1;
        if1.in_valid = 1'b0;
        #1;
        check("rel_ready", 32'(if1.in_ready), 32'd1);
        tick();
        check("rel_level", 32'(level1), 32'd0);
        check("rel_busy",  32'(busy1),  32'd0);

        // ---- Single word 3'b101 on GAP=1 ----
        if1.in_data  = 3'b101;
        if1.in_valid = 1'b1;
        tick();                                 // edge 1: push
        if1.in_valid = 1'b0;
        check("sw_level1", 32'(level1), 32'd1);
        check("sw_y_e1",   32'(y1),     32'd0);
        tick();                                 // edge 2: strobe
        check("sw_y_e2",   32'(y1),     32'd1);
        check("sw_x_e2",   32'(x1),     32'd5);
        tick();                                 // edge 3: into WAIT
        check("sw_y_e3",   32'(y1),     32'd0);
        check("sw_x_e3",   32'(x1),     32'd5);
        check("sw_busy_e3",32'(busy1),  32'd1);
        tick();                                 // edge 4: back to IDLE
        check("sw_busy_e4",32'(busy1),  32'd0);
        check("sw_x_e4",   32'(x1),     32'd5);

        // ---- Stream 1,2,3,4 into GAP=1 and GAP=0 together ----
        if1.in_data = 3'd1; if1.in_valid = 1'b1;
        if0.in_data = 3'd1; if0.in_valid = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c < 4) begin
                if1.in_data = 3'(c + 1);
                if0.in_data = 3'(c + 1);
            end else begin
                if1.in_valid = 1'b0;
                if0.in_valid = 1'b0;
            end
            $display("stream cycle %0d: g1 y=%0d x=%0d  g0 y=%0d x=%0d", c, y1, x1, y0, x0);
            check("stream_g1_y", 32'(y1), (e1[c-1] != 0) ? 32'd1 : 32'd0);
            if (e1[c-1] != 0) check("stream_g1_x", 32'(x1), 32'(e1[c-1]));
            check("stream_g0_y", 32'(y0), (e0[c-1] != 0) ? 32'd1 : 32'd0);
            if (e0[c-1] != 0) check("stream_g0_x", 32'(x0), 32'(e0[c-1]));
        end
        check("stream_g1_busy", 32'(busy1), 32'd0);
        check("stream_g0_busy", 32'(busy0), 32'd0);

        // ---- Fill, GAP=3: 8 words, in_valid held while words remain ----
        idx     = 0;
        strobes = 0;
        if3.in_valid = 1'b1;
        if3.in_data  = w3[0];
        for (int c = 1; c <= 35; c++) begin
            rdy = if3.in_ready;
            tick();
            if (rdy && if3.in_valid) begin
                idx++;
                if (idx == 8) if3.in_valid = 1'b0;
                else          if3.in_data  = w3[idx];
            end
            $display("fill cycle %0d: y=%0d x=%0d level=%0d ready=%0d", c, y3, x3, level3, if3.in_ready);
            if (c >= 2 && c <= 30 && ((c - 2) % 4) == 0) begin
                exp_x = int'(w3[(c - 2) / 4]);
                check("fill_y", 32'(y3), 32'd1);
                check("fill_x", 32'(x3), 32'(exp_x));
            end else begin
                check("fill_y", 32'(y3), 32'd0);
            end
            if (y3) strobes++;
            if (c == 5) begin
                check("fill_level_full", 32'(level3),       32'd4);
                check("fill_ready_full", 32'(if3.in_ready), 32'd0);
            end
            if (c == 6) check("fill_pop_no_push", 32'(level3), 32'd3);
            if (c == 9) check("fill_ready_c9",    32'(if3.in_ready), 32'd0);
        end
        check("fill_accepted", 32'(idx),     32'd8);
        check("fill_strobes",  32'(strobes), 32'd8);
        check("fill_busy",     32'(busy3),   32'd0);

        // ---- Reset mid-stream on GAP=1 ----
        if1.in_data = 3'd1; if1.in_valid = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c < 6) if1.in_data = 3'(c + 1);
            else       if1.in_valid = 1'b0;
        end
        check("mid_pre_y",     32'(y1),     32'd1);
        check("mid_pre_level", 32'(level1), 32'd3);
        check("mid_pre_x",     32'(x1),     32'd3);
        rst_n = 1'b0;
        tick();
        check("mid_rst_y",     32'(y1),           32'd0);
        check("mid_rst_level", 32'(level1),       32'd0);
        check("mid_rst_busy",  32'(busy1),        32'd0);
        check("mid_rst_x",     32'(x1),           32'd0);
        check("mid_rst_ready", 32'(if1.in_ready), 32'd0);
        rst_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            check("mid_after_y",     32'(y1),     32'd0);
            check("mid_after_level", 32'(level1), 32'd0);
        end

        // ---- Fresh word after reset, then parity pair 111 / 110 ----
        if1.in_data = 3'b010; if1.in_valid = 1'b1;
        tick();
        if1.in_valid = 1'b0;
        tick();
        check("post_y", 32'(y1), 32'd1);
        check("post_x", 32'(x1), 32'd2);
        tick();
        tick();
        check("post_busy", 32'(busy1), 32'd0);

        if1.in_data = 3'b111; if1.in_valid = 1'b1;
        tick();
        if1.in_data = 3'b110;
        tick();
        if1.in_valid = 1'b0;
        check("par_y_a", 32'(y1), 32'd1);
        check("par_x_a", 32'(x1), 32'd7);
`ifdef STROBE_TX_PARITY_EN
        check("par_p_a", 32'(p1), 32'd1);
`endif
        tick();
        check("par_y_hold", 32'(y1), 32'd0);
        check("par_x_hold", 32'(x1), 32'd7);
`ifdef STROBE_TX_PARITY_EN
        check("par_p_hold", 32'(p1), 32'd1);
`endif
        tick();
        check("par_y_b", 32'(y1), 32'd1);
        check("par_x_b", 32'(x1), 32'd6);
`ifdef STROBE_TX_PARITY_EN
        check("par_p_b", 32'(p1), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
